// File: rtl/key_debounce_repeat.sv
// Push-button conditioner: 2-FF sync, tick-based debounce, press/release pulses and hold auto-repeat.
// Auto-repeat (hold/repeat counters, key_repeat, key_long) exists only when KEY_REPEAT_EN is defined.
module key_debounce_repeat #(
  parameter int TICK_DIV    = 50000,
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 600,
  parameter int REPEAT_MS   = 150
) (
  input  logic clk,
  input  logic rst,
  input  logic key_N,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat,
  output logic key_long
);

  localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_MS + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]  DB_FULL  = DB_W'(DEBOUNCE_MS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } state_t;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             s_key;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;
  logic [DB_W-1:0]  db_q, db_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             accept;
  logic             accept_press;
  logic             accept_release;
  state_t           state_q, state_d;

  always_comb begin
    sync1_d = key_N;
    sync2_d = sync1_q;
  end

  assign s_key = ~sync2_q;
  assign tick  = (pre_q == PRE_LAST);

  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  // The acceptance tick is the (DEBOUNCE_MS+1)-th tick of a disagreement run, so the
  // partial tick period in which the level first changed never counts as stable time.
  always_comb begin
    db_d      = db_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    accept    = 1'b0;
    if (s_key == level_q) begin
      db_d = '0;
    end else if (tick) begin
      if (db_q == DB_FULL) begin
        accept    = 1'b1;
        level_d   = ~level_q;
        db_d      = '0;
        press_d   = ~level_q;
        release_d = level_q;
      end else begin
        db_d = db_q + 1'b1;
      end
    end
  end

  assign accept_press   = accept & ~level_q;
  assign accept_release = accept & level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      pre_q     <= '0;
      db_q      <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      pre_q     <= pre_d;
      db_q      <= db_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int H_W = $clog2(HOLD_MS + 1);
  localparam int R_W = $clog2(REPEAT_MS + 1);

  localparam logic [H_W-1:0] HOLD_LAST = H_W'(HOLD_MS - 1);
  localparam logic [R_W-1:0] REP_LAST  = R_W'(REPEAT_MS - 1);

  logic [H_W-1:0] hold_q, hold_d;
  logic [R_W-1:0] rep_q, rep_d;
  logic           repeat_q, repeat_d;
  logic           long_q, long_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rep_q   <= rep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rep_d   = rep_q;
    case (state_q)
      IDLE: begin
        if (accept_press) begin
          state_d = PRESSED;
          hold_d  = '0;
        end
      end
      PRESSED: begin
        if (accept_release) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (tick) begin
          if (hold_q == HOLD_LAST) begin
            state_d = REPEAT;
            hold_d  = '0;
            rep_d   = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      REPEAT: begin
        if (accept_release) begin
          state_d = IDLE;
          rep_d   = '0;
        end else if (tick) begin
          rep_d = (rep_q == REP_LAST) ? '0 : rep_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
        rep_d   = '0;
      end
    endcase
  end

  // A release accepted on the same tick as a due repeat suppresses the repeat.
  always_comb begin
    repeat_d = 1'b0;
    case (state_q)
      PRESSED: repeat_d = tick & ~accept_release & (hold_q == HOLD_LAST);
      REPEAT:  repeat_d = tick & ~accept_release & (rep_q == REP_LAST);
      default: repeat_d = 1'b0;
    endcase
    long_d = (state_d == REPEAT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      repeat_q <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      repeat_q <= repeat_d;
      long_q   <= long_d;
    end
  end

  assign key_repeat = repeat_q;
  assign key_long   = long_q;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_press)   state_d = PRESSED;
      PRESSED: if (accept_release) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign key_repeat = 1'b0;
  assign key_long   = 1'b0;
`endif

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: tb/tb_key_debounce_repeat.sv
module tb_key_debounce_repeat;
  localparam int T  = 4;
  localparam int DB = 3;
  localparam int H  = 10;
  localparam int R  = 4;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic key_N = 1'b1;
  logic key_level, key_press, key_release, key_repeat, key_long;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  key_debounce_repeat #(
    .TICK_DIV(T), .DEBOUNCE_MS(DB), .HOLD_MS(H), .REPEAT_MS(R)
  ) dut (
    .clk(clk), .rst(rst), .key_N(key_N),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_repeat(key_repeat), .key_long(key_long)
  );

  // Reference model: timing expressed as cycle arithmetic on the tick grid.
  logic m_k1 = 1'b1, m_k2 = 1'b1, m_s = 1'b0;
  logic m_level = 1'b0, m_press = 1'b0, m_release = 1'b0, m_repeat = 1'b0, m_long = 1'b0;
  logic m_tick = 1'b0, m_acc = 1'b0;
  int   m_c = 0, m_since = -1, m_pa = 0, m_d = 0;

  wire [4:0] dut_v = {key_level, key_press, key_release, key_repeat, key_long};
  wire [4:0] mdl_v = {m_level, m_press, m_release, m_repeat, m_long};

  function automatic int ticks_in(int a, int b);
    return (b + 1) / T - a / T;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k1 = 1'b1; m_k2 = 1'b1; m_c = 0; m_since = -1; m_pa = 0;
      m_level = 1'b0; m_press = 1'b0; m_release = 1'b0; m_repeat = 1'b0; m_long = 1'b0;
    end else begin
      m_press = 1'b0; m_release = 1'b0; m_repeat = 1'b0;
      m_s    = ~m_k2;
      m_tick = (m_c % T) == T - 1;
      if (m_s == m_level) m_since = -1;
      else if (m_since < 0) m_since = m_c;
      m_acc = m_tick && (m_since >= 0) && (ticks_in(m_since, m_c) == DB + 1);
`ifdef KEY_REPEAT_EN
      if (m_level && !m_acc) begin
        m_d = m_c - m_pa;
        if (m_d >= H * T && ((m_d - H * T) % (R * T)) == 0) m_repeat = 1'b1;
      end
`endif
      if (m_acc) begin
        m_level = ~m_level;
        m_since = -1;
        if (m_level) begin
          m_press = 1'b1;
          m_pa    = m_c;
        end else begin
          m_release = 1'b1;
        end
      end
`ifdef KEY_REPEAT_EN
      m_long = m_level && ((m_c - m_pa) >= H * T);
`else
      m_long = 1'b0;
`endif
      m_k2 = m_k1;
      m_k1 = key_N;
      m_c++;
    end
  end

  task automatic test_reset();
    rst   = 1'b1;
    key_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (dut_v !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc %0d: got %b expected 00000", i, dut_v);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_clean_press();
    int first, np, nr;
    first = -1; np = 0; nr = 0;
    repeat ($urandom_range(0, 7)) @(negedge clk);
    key_N = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      n_tests++;
      if (dut_v !== mdl_v) begin
        n_fail++;
        $display("FAIL clean_model cyc %0d: got %b expected %b", i, dut_v, mdl_v);
      end
      if (key_press) begin np++; if (first < 0) first = i; end
      if (key_release) nr++;
    end
    n_tests++;
    if (np != 1) begin n_fail++; $display("FAIL clean_press_count: got %0d expected 1", np); end
    n_tests++;
    if (first < 14 || first > 18) begin
      n_fail++; $display("FAIL clean_press_latency: got %0d expected 14..18", first);
    end
    n_tests++;
    if (nr != 0) begin n_fail++; $display("FAIL clean_no_release: got %0d expected 0", nr); end
    n_tests++;
    if (key_level !== 1'b1) begin n_fail++; $display("FAIL clean_level: got %b expected 1", key_level); end
    key_N = 1'b1;
    nr = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      n_tests++;
      if (dut_v !== mdl_v) begin
        n_fail++;
        $display("FAIL clean_rel_model cyc %0d: got %b expected %b", i, dut_v, mdl_v);
      end
      if (key_release) nr++;
    end
    n_tests++;
    if (nr != 1) begin n_fail++; $display("FAIL clean_release_count: got %0d expected 1", nr); end
    n_tests++;
    if (key_level !== 1'b0) begin n_fail++; $display("FAIL clean_level_after: got %b expected 0", key_level); end
  endtask

  task automatic test_bounce();
    int first, np_bounce, np;
    first = -1; np_bounce = 0; np = 0;
    key_N = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      n_tests++;
      if (dut_v !== mdl_v) begin
        n_fail++;
        $display("FAIL bounce_model cyc %0d: got %b expected %b", i, dut_v, mdl_v);
      end
      if (key_press || key_release) np_bounce++;
      if (i % 5 == 0) key_N = ~key_N;
    end
    key_N = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      n_tests++;
      if (dut_v !== mdl_v) begin
        n_fail++;
        $display("FAIL bounce_settle_model cyc %0d: got %b expected %b", i, dut_v, mdl_v);
      end
      if (key_press) begin np++; if (first < 0) first = i; end
    end
    n_tests++;
    if (np_bounce != 0) begin n_fail++; $display("FAIL bounce_quiet: got %0d pulses expected 0", np_bounce); end
    n_tests++;
    if (np != 1 || first < 14 || first > 18) begin
      n_fail++; $display("FAIL bounce_press: got count %0d at %0d expected 1 at 14..18", np, first);
    end
    key_N = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      n_tests++;
      if (dut_v !== mdl_v) begin
        n_fail++;
        $display("FAIL bounce_rel_model cyc %0d: got %b expected %b", i, dut_v, mdl_v);
      end
    end
  endtask

  task automatic test_glitch();
    int np, lv;
    np = 0; lv = 0;
    key_N = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      n_tests++;
      if (dut_v !== mdl_v) begin
        n_fail++;
        $display("FAIL glitch_model cyc %0d: got %b expected %b", i, dut_v, mdl_v);
      end
      if (key_press) np++;
      if (key_level) lv++;
      if (i == 8) key_N = 1'b1;
    end
    n_tests++;
    if (np != 0 || lv != 0) begin
      n_fail++; $display("FAIL glitch_reject: got %0d presses %0d level cycles expected 0 0", np, lv);
    end
  endtask

`ifdef KEY_REPEAT_EN
  task automatic test_hold();
    int press_at, first_rep, last_rep, bad_gap, nrep, nr, rep_after;
    logic long_first, released;
    press_at = -1; first_rep = -1; last_rep = -1; bad_gap = 0; nrep = 0;
    long_first = 1'b0; nr = 0; rep_after = 0; released = 1'b0;
    key_N = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      n_tests++;
      if (dut_v !== mdl_v) begin
        n_fail++;
        $display("FAIL hold_model cyc %0d: got %b expected %b", i, dut_v, mdl_v);
      end
      if (key_press) press_at = i;
      if (key_repeat) begin
        nrep++;
        if (first_rep < 0) begin
          first_rep  = i;
          long_first = key_long;
        end else if (i - last_rep != R * T) begin
          bad_gap++;
        end
        last_rep = i;
      end
    end
    n_tests++;
    if (first_rep - press_at != H * T) begin
      n_fail++; $display("FAIL hold_first_repeat: got %0d expected %0d", first_rep - press_at, H * T);
    end
    n_tests++;
    if (bad_gap != 0 || nrep < 8) begin
      n_fail++; $display("FAIL hold_repeat_period: got %0d bad gaps %0d repeats expected 0 and >=8", bad_gap, nrep);
    end
    n_tests++;
    if (long_first !== 1'b1) begin n_fail++; $display("FAIL hold_long_at_first: got %b expected 1", long_first); end
    key_N = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      n_tests++;
      if (dut_v !== mdl_v) begin
        n_fail++;
        $display("FAIL hold_rel_model cyc %0d: got %b expected %b", i, dut_v, mdl_v);
      end
      if (released && key_repeat) rep_after++;
      if (key_release) begin nr++; released = 1'b1; end
    end
    n_tests++;
    if (nr != 1 || rep_after != 0 || key_long !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: got rel %0d rep_after %0d long %b expected 1 0 0", nr, rep_after, key_long);
    end
  endtask
`else
  task automatic test_no_repeat();
    int np, nr, nrep, nlong;
    np = 0; nr = 0; nrep = 0; nlong = 0;
    key_N = 1'b0;
    for (int i = 1; i <= 240; i++) begin
      @(negedge clk);
      n_tests++;
      if (dut_v !== mdl_v) begin
        n_fail++;
        $display("FAIL norep_model cyc %0d: got %b expected %b", i, dut_v, mdl_v);
      end
      if (key_press) np++;
      if (key_release) nr++;
      if (key_repeat) nrep++;
      if (key_long) nlong++;
      if (i == 200) key_N = 1'b1;
    end
    n_tests++;
    if (nrep != 0 || nlong != 0) begin
      n_fail++; $display("FAIL norep_quiet: got rep %0d long %0d expected 0 0", nrep, nlong);
    end
    n_tests++;
    if (np != 1 || nr != 1) begin
      n_fail++; $display("FAIL norep_pulses: got press %0d release %0d expected 1 1", np, nr);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int first;
    first = -1;
    key_N = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      n_tests++;
      if (dut_v !== mdl_v) begin
        n_fail++;
        $display("FAIL rstmid_model cyc %0d: got %b expected %b", i, dut_v, mdl_v);
      end
    end
`ifdef KEY_REPEAT_EN
    n_tests++;
    if (key_long !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_repeat: got %b expected 1", key_long); end
`endif
    rst = 1'b1;
    #1;
    n_tests++;
    if (dut_v !== 5'b0) begin n_fail++; $display("FAIL rstmid_clear: got %b expected 00000", dut_v); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      n_tests++;
      if (dut_v !== mdl_v) begin
        n_fail++;
        $display("FAIL rstmid_after_model cyc %0d: got %b expected %b", i, dut_v, mdl_v);
      end
      if (key_press && first < 0) first = i;
    end
    n_tests++;
    if (first < 14 || first > 18) begin
      n_fail++; $display("FAIL rstmid_repress: got %0d expected 14..18", first);
    end
    key_N = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      n_tests++;
      if (dut_v !== mdl_v) begin
        n_fail++;
        $display("FAIL rstmid_rel_model cyc %0d: got %b expected %b", i, dut_v, mdl_v);
      end
    end
  endtask

  task automatic test_random();
    int len;
    for (int s = 0; s < 40; s++) begin
      key_N = 1'($urandom_range(0, 1));
      len   = $urandom_range(1, 30);
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        n_tests++;
        if (dut_v !== mdl_v) begin
          n_fail++;
          $display("FAIL random_model seg %0d cyc %0d: got %b expected %b", s, i, dut_v, mdl_v);
        end
      end
    end
    key_N = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      n_tests++;
      if (dut_v !== mdl_v) begin
        n_fail++;
        $display("FAIL random_tail_model cyc %0d: got %b expected %b", i, dut_v, mdl_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
`ifdef KEY_REPEAT_EN
    test_hold();
`else
    test_no_repeat();
`endif
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
